// File: rtl/debug_cmd_sync_queue.sv
// Synchronizes JTAG update-DR/update-IR levels into clk and queues captured {ir, data}
// commands in a small FIFO with registered head outputs and one-hot action strobes.
module debug_cmd_sync_queue #(
   parameter int DATA_W       = 38,
   parameter int IR_W         = 2,
   parameter int SYNC_STAGES  = 2,
   parameter int DEPTH        = 4,
   parameter int FLUSH_ON_UIR = 0,
   localparam int ACT_N       = 2**IR_W,
   localparam int AW          = $clog2(DEPTH),
   localparam int LW          = AW + 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [IR_W-1:0]   ir_in,
   input  logic [DATA_W-1:0] sr,
   input  logic              vs_udr,
   input  logic              vs_uir,
   input  logic              jdo_ready,
   input  logic              clear_overrun,
   output logic [DATA_W-1:0] jdo,
   output logic [IR_W-1:0]   jdo_ir,
   output logic              jdo_valid,
   output logic [ACT_N-1:0]  take_action,
   output logic              uir_pulse,
   output logic              overrun,
   output logic [LW-1:0]     level
);

   logic [SYNC_STAGES-1:0]   udr_sync_q, uir_sync_q, fill_q;
   logic                     udr_prev_q, uir_prev_q, udr_arm_q, uir_arm_q;
   logic                     udr_lvl, uir_lvl, fill_done, udr_evt, uir_evt;

   logic [IR_W+DATA_W-1:0]   mem_q [DEPTH];
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_idx;
   logic [LW-1:0]            level_q, level_d;
   logic [DATA_W-1:0]        jdo_q, jdo_d;
   logic [IR_W-1:0]          jdo_ir_q, jdo_ir_d;
   logic                     jdo_valid_q, jdo_valid_d;
   logic [ACT_N-1:0]         take_action_q, take_action_d;
   logic                     uir_pulse_q, uir_pulse_d;
   logic                     overrun_q, overrun_d;
   logic                     flush, pop, push, drop, full;

   assign udr_lvl   = udr_sync_q[SYNC_STAGES-1];
   assign uir_lvl   = uir_sync_q[SYNC_STAGES-1];
   // Synchronizer outputs only reflect real input samples once the chain has refilled after
   // reset; arming waits for that so a level held high across reset never looks like an edge.
   assign fill_done = fill_q[SYNC_STAGES-1];
   assign udr_evt   = udr_arm_q & udr_lvl & ~udr_prev_q;
   assign uir_evt   = uir_arm_q & uir_lvl & ~uir_prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         udr_sync_q <= '0;
         uir_sync_q <= '0;
         fill_q     <= '0;
         udr_prev_q <= 1'b0;
         uir_prev_q <= 1'b0;
         udr_arm_q  <= 1'b0;
         uir_arm_q  <= 1'b0;
      end else begin
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         udr_prev_q <= udr_lvl;
         uir_prev_q <= uir_lvl;
         udr_arm_q  <= udr_arm_q | (fill_done & ~udr_lvl);
         uir_arm_q  <= uir_arm_q | (fill_done & ~uir_lvl);
      end
   end

   // Handshake: the head entry transfers on a rising clk edge where jdo_valid and jdo_ready
   // are both 1; jdo_ready while jdo_valid is 0 has no effect, and valid never depends on ready.
   // The head register only shows entries stored before the current edge, so a push becomes
   // visible one edge after it is written.
   always_comb begin
      flush         = (FLUSH_ON_UIR != 0) && uir_evt;
      full          = (level_q == LW'(DEPTH));
      pop           = jdo_valid_q & jdo_ready & ~flush;
      push          = udr_evt & ~flush & (~full | pop);
      drop          = udr_evt & ~flush & full & ~pop;
      head_idx      = rd_ptr_q + AW'(pop);
      wr_ptr_d      = wr_ptr_q + AW'(push);
      rd_ptr_d      = head_idx;
      level_d       = level_q + LW'(push) - LW'(pop);
      jdo_valid_d   = ((level_q - LW'(pop)) != '0);
      jdo_d         = jdo_q;
      jdo_ir_d      = jdo_ir_q;
      take_action_d = pop ? (ACT_N'(1) << jdo_ir_q) : '0;
      uir_pulse_d   = uir_evt;
      overrun_d     = overrun_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         jdo_valid_d = 1'b0;
      end
      if (jdo_valid_d) begin
         jdo_d    = mem_q[head_idx][DATA_W-1:0];
         jdo_ir_d = mem_q[head_idx][DATA_W +: IR_W];
      end
      if (drop) begin
         overrun_d = 1'b1;
      end else if (clear_overrun) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {ir_in, sr};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         jdo_q         <= '0;
         jdo_ir_q      <= '0;
         jdo_valid_q   <= 1'b0;
         take_action_q <= '0;
         uir_pulse_q   <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         jdo_q         <= jdo_d;
         jdo_ir_q      <= jdo_ir_d;
         jdo_valid_q   <= jdo_valid_d;
         take_action_q <= take_action_d;
         uir_pulse_q   <= uir_pulse_d;
         overrun_q     <= overrun_d;
      end
   end

   assign jdo         = jdo_q;
   assign jdo_ir      = jdo_ir_q;
   assign jdo_valid   = jdo_valid_q;
   assign take_action = take_action_q;
   assign uir_pulse   = uir_pulse_q;
   assign overrun     = overrun_q;
   assign level       = level_q;

endmodule

// File: tb/tb_debug_cmd_sync_queue.sv
// Directed bench for debug_cmd_sync_queue: default instance plus a
// 3-bit IR / 16-bit data / 3-stage / flush-on-uir instance.
module tb_debug_cmd_sync_queue;

   localparam int W = 40;

   logic clk, reset_n;

   logic [1:0]  ir1;
   logic [37:0] sr1;
   logic        vs_udr1, vs_uir1, rdy1, clr1;
   logic [37:0] jdo1;
   logic [1:0]  jdo_ir1;
   logic        valid1, uir_p1, ovr1;
   logic [3:0]  ta1;
   logic [2:0]  level1;

   logic [2:0]  ir2;
   logic [15:0] sr2;
   logic        vs_udr2, vs_uir2, rdy2, clr2;
   logic [15:0] jdo2;
   logic [2:0]  jdo_ir2;
   logic        valid2, uir_p2, ovr2;
   logic [7:0]  ta2;
   logic [2:0]  level2;

   logic [W-1:0] exp_q[$];
   int           total = 0;
   int           bad = 0;
   int           m_level = 0;

   debug_cmd_sync_queue dut1 (
      .clk(clk), .reset_n(reset_n), .ir_in(ir1), .sr(sr1), .vs_udr(vs_udr1), .vs_uir(vs_uir1),
      .jdo_ready(rdy1), .clear_overrun(clr1), .jdo(jdo1), .jdo_ir(jdo_ir1), .jdo_valid(valid1),
      .take_action(ta1), .uir_pulse(uir_p1), .overrun(ovr1), .level(level1)
   );

   debug_cmd_sync_queue #(.DATA_W(16), .IR_W(3), .SYNC_STAGES(3), .DEPTH(4), .FLUSH_ON_UIR(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .ir_in(ir2), .sr(sr2), .vs_udr(vs_udr2), .vs_uir(vs_uir2),
      .jdo_ready(rdy2), .clear_overrun(clr2), .jdo(jdo2), .jdo_ir(jdo_ir2), .jdo_valid(valid2),
      .take_action(ta2), .uir_pulse(uir_p2), .overrun(ovr2), .level(level2)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic udr_event1(input logic [1:0] ir, input logic [37:0] d);
      ir1 = ir;
      sr1 = d;
      vs_udr1 = 1'b1;
      repeat (4) tick();
      vs_udr1 = 1'b0;
      repeat (3) tick();
      if (m_level < 4) begin
         exp_q.push_back({ir, d});
         m_level++;
      end
   endtask

   task automatic do_pop1();
      logic [W-1:0] e;
      logic [1:0]   e_ir;
      chk("pop_valid", valid1, 1);
      if (exp_q.size() == 0) begin
         chk("pop_queue_nonempty", 0, 1);
      end else begin
         e = exp_q.pop_front();
         e_ir = e[39:38];
         chk("pop_jdo", jdo1, e[37:0]);
         chk("pop_jdo_ir", jdo_ir1, e_ir);
         rdy1 = 1'b1;
         tick();
         rdy1 = 1'b0;
         m_level--;
         chk("pop_take_action", ta1, 4'b0001 << e_ir);
         chk("pop_level", level1, m_level);
         tick();
         chk("pop_take_action_clear", ta1, 0);
      end
   endtask

   initial begin
      logic [63:0]  r;
      logic [W-1:0] e;
      logic [1:0]   e_ir;
      logic [1:0]   n_ir;
      logic [37:0]  n_sr;

      reset_n = 1'b0;
      ir1 = '0; sr1 = '0; vs_udr1 = 0; vs_uir1 = 0; rdy1 = 0; clr1 = 0;
      ir2 = '0; sr2 = '0; vs_udr2 = 0; vs_uir2 = 0; rdy2 = 0; clr2 = 0;
      #3;
      chk("rst_level", level1, 0);
      chk("rst_valid", valid1, 0);
      chk("rst_jdo", jdo1, 0);
      chk("rst_ta", ta1, 0);
      chk("rst_uir", uir_p1, 0);
      chk("rst_ovr", ovr1, 0);
      tick();
      reset_n = 1'b1;
      repeat (6) tick();

      // first capture: exact latency
      ir1 = 2'b01;
      sr1 = 38'h15_5555_5555;
      vs_udr1 = 1'b1;
      tick(); tick();
      chk("lat_valid_e2", valid1, 0);
      tick();
      chk("lat_valid_e3", valid1, 0);
      chk("lat_level_e3", level1, 1);
      tick();
      chk("lat_valid_e4", valid1, 1);
      exp_q.push_back({2'b01, 38'h15_5555_5555});
      m_level = 1;
      vs_udr1 = 1'b0;
      repeat (3) tick();
      do_pop1();

      // ready while empty
      rdy1 = 1'b1;
      repeat (3) tick();
      chk("empty_ready_ta", ta1, 0);
      chk("empty_ready_level", level1, 0);
      rdy1 = 1'b0;

      // overflow
      for (int i = 0; i < 5; i++) begin
         r = {$urandom, $urandom};
         udr_event1(2'($urandom_range(0, 3)), r[37:0]);
      end
      chk("ovf_level", level1, 4);
      chk("ovf_overrun", ovr1, 1);
      clr1 = 1'b1;
      tick();
      clr1 = 1'b0;
      chk("ovr_clear", ovr1, 0);
      do_pop1();
      do_pop1();
      for (int i = 0; i < 2; i++) begin
         r = {$urandom, $urandom};
         udr_event1(2'($urandom_range(0, 3)), r[37:0]);
      end
      chk("refill_level", level1, 4);

      // push and pop on the same edge while full
      r = {$urandom, $urandom};
      n_ir = 2'($urandom_range(0, 3));
      n_sr = r[37:0];
      ir1 = n_ir;
      sr1 = n_sr;
      vs_udr1 = 1'b1;
      tick(); tick();
      e = exp_q.pop_front();
      e_ir = e[39:38];
      chk("full_pp_jdo", jdo1, e[37:0]);
      rdy1 = 1'b1;
      tick();
      rdy1 = 1'b0;
      exp_q.push_back({n_ir, n_sr});
      chk("full_pp_ta", ta1, 4'b0001 << e_ir);
      chk("full_pp_level", level1, 4);
      chk("full_pp_ovr", ovr1, 0);
      vs_udr1 = 1'b0;
      repeat (3) tick();
      repeat (4) do_pop1();
      tick();
      chk("drain_valid", valid1, 0);

      // uir pulse, no flush on this instance
      vs_uir1 = 1'b1;
      tick(); tick();
      chk("uir_e2", uir_p1, 0);
      tick();
      chk("uir_e3", uir_p1, 1);
      tick();
      chk("uir_e4", uir_p1, 0);
      vs_uir1 = 1'b0;

      // reset mid-operation with vs_udr held high across release
      for (int i = 0; i < 2; i++) begin
         r = {$urandom, $urandom};
         udr_event1(2'($urandom_range(0, 3)), r[37:0]);
      end
      chk("pre_rst_level", level1, 2);
      vs_udr1 = 1'b1;
      tick();
      reset_n = 1'b0;
      #2;
      chk("async_rst_level", level1, 0);
      chk("async_rst_valid", valid1, 0);
      exp_q.delete();
      m_level = 0;
      tick();
      reset_n = 1'b1;
      repeat (10) begin
         tick();
         total++;
         assert (ta1 === 4'b0 && level1 === 3'd0) else begin
            bad++;
            $error("FAIL held_udr_no_push observed=%0h/%0h expected=0/0", ta1, level1);
         end
      end
      vs_udr1 = 1'b0;
      repeat (4) tick();
      udr_event1(2'b11, 38'h2A_0F0F_1234);
      chk("after_rst_level", level1, 1);
      do_pop1();

      // second instance: latency and wide strobe
      ir2 = 3'd6;
      sr2 = 16'hBEEF;
      vs_udr2 = 1'b1;
      repeat (4) tick();
      chk("i2_valid_e4", valid2, 0);
      chk("i2_level_e4", level2, 1);
      tick();
      chk("i2_valid_e5", valid2, 1);
      chk("i2_jdo", jdo2, 16'hBEEF);
      chk("i2_jdo_ir", jdo_ir2, 6);
      vs_udr2 = 1'b0;
      repeat (4) tick();
      rdy2 = 1'b1;
      tick();
      rdy2 = 1'b0;
      chk("i2_ta", ta2, 8'h40);
      chk("i2_pop_level", level2, 0);
      tick();
      chk("i2_ta_clear", ta2, 0);

      // second instance: flush on uir
      for (int i = 0; i < 3; i++) begin
         ir2 = 3'(i);
         sr2 = 16'h1000 + 16'(i);
         vs_udr2 = 1'b1;
         repeat (5) tick();
         vs_udr2 = 1'b0;
         repeat (4) tick();
      end
      chk("i2_level3", level2, 3);
      vs_uir2 = 1'b1;
      repeat (3) tick();
      chk("i2_uir_e3", uir_p2, 0);
      tick();
      chk("i2_uir_e4", uir_p2, 1);
      chk("i2_flush_level", level2, 0);
      chk("i2_flush_valid", valid2, 0);
      chk("i2_flush_ta", ta2, 0);
      chk("i2_hold_jdo", jdo2, 16'h1000);
      tick();
      chk("i2_uir_e5", uir_p2, 0);
      chk("i2_flush_ta2", ta2, 0);
      vs_uir2 = 1'b0;
      ir2 = 3'd5;
      sr2 = 16'h7777;
      vs_udr2 = 1'b1;
      repeat (6) tick();
      vs_udr2 = 1'b0;
      chk("i2_post_flush_level", level2, 1);
      chk("i2_post_flush_jdo", jdo2, 16'h7777);

      // report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
